// File: rtl/td4_pkg.sv
// Shared opcodes, FSM state encoding and adder operand selects for the TD4 sequencer.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_STALL = 2'b11
  } state_t;

endpackage

// File: rtl/td4_decoder.sv
// Combinational TD4 instruction decoder: opcode and carry flag in, datapath controls out.
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output logic [1:0] sel,
  output logic       imm_en,
  output logic       wr_a,
  output logic       wr_b,
  output logic       wr_out,
  output logic       jump_taken,
  output logic       carry_load
);

  always_comb begin
    sel        = SEL_ZERO;
    imm_en     = 1'b0;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    wr_out     = 1'b0;
    jump_taken = 1'b0;
    carry_load = 1'b0;
    case (opcode)
      OP_ADD_A:  begin sel = SEL_A;    imm_en = 1'b1; wr_a = 1'b1; carry_load = 1'b1; end
      OP_ADD_B:  begin sel = SEL_B;    imm_en = 1'b1; wr_b = 1'b1; carry_load = 1'b1; end
      OP_MOV_A:  begin sel = SEL_ZERO; imm_en = 1'b1; wr_a = 1'b1; end
      OP_MOV_B:  begin sel = SEL_ZERO; imm_en = 1'b1; wr_b = 1'b1; end
      OP_MOV_AB: begin sel = SEL_B;    wr_a = 1'b1; end
      OP_MOV_BA: begin sel = SEL_A;    wr_b = 1'b1; end
      OP_IN_A:   begin sel = SEL_IN;   wr_a = 1'b1; end
      OP_IN_B:   begin sel = SEL_IN;   wr_b = 1'b1; end
      OP_OUT_B:  begin sel = SEL_B;    wr_out = 1'b1; end
      OP_OUT_IM: begin sel = SEL_ZERO; imm_en = 1'b1; wr_out = 1'b1; end
      OP_JMP:    jump_taken = 1'b1;
      // JNC looks at the flag as it stood before this instruction
      OP_JNC:    jump_taken = ~carry;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control unit: fetch over req/ack, one-cycle execute, owns pc and carry.
// Optional single-step mode via TD4_SINGLE_STEP_EN (adds the step input and STALL state).
//
// state | meaning
// RESET | just out of reset, moves to FETCH next cycle
// FETCH | imem_req high at imem_addr=pc, waits for imem_ack
// EXEC  | decode ir, pulse write strobe, update pc and carry
// STALL | single-step only: wait for step before next fetch
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int PC_WIDTH   = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef TD4_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [7:0]            imem_data,
  output logic [1:0]            alu_src_sel,
  output logic [DATA_WIDTH-1:0] imm_o,
  input  logic                  alu_carry,
  output logic                  wr_a,
  output logic                  wr_b,
  output logic                  wr_out,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  carry,
  output logic [1:0]            state_o
);

  state_t     state;
  logic [7:0] ir;
  logic       exec;
  logic [1:0] dec_sel;
  logic       dec_imm_en;
  logic       dec_wr_a;
  logic       dec_wr_b;
  logic       dec_wr_out;
  logic       dec_jump;
  logic       dec_carry_load;

  td4_decoder u_decoder (
    .opcode     (ir[7:4]),
    .carry      (carry),
    .sel        (dec_sel),
    .imm_en     (dec_imm_en),
    .wr_a       (dec_wr_a),
    .wr_b       (dec_wr_b),
    .wr_out     (dec_wr_out),
    .jump_taken (dec_jump),
    .carry_load (dec_carry_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      pc       <= '0;
      carry    <= 1'b0;
      imem_req <= 1'b0;
      ir       <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_data;
            state    <= ST_EXEC;
            imem_req <= 1'b0;
          end
        end
        ST_EXEC: begin
          pc    <= dec_jump ? PC_WIDTH'(ir[3:0]) : pc + PC_WIDTH'(1);
          carry <= dec_carry_load & alu_carry;
`ifdef TD4_SINGLE_STEP_EN
          state <= ST_STALL;
`else
          state    <= ST_FETCH;
          imem_req <= 1'b1;
`endif
        end
        ST_STALL: begin
`ifdef TD4_SINGLE_STEP_EN
          if (step) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
`else
          state    <= ST_FETCH;
          imem_req <= 1'b1;
`endif
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  // Datapath controls are decoded from the registered ir, so they only change on state edges
  assign exec        = (state == ST_EXEC);
  assign alu_src_sel = exec ? dec_sel : SEL_ZERO;
  assign imm_o       = (exec && dec_imm_en) ? DATA_WIDTH'(ir[3:0]) : '0;
  assign wr_a        = exec & dec_wr_a;
  assign wr_b        = exec & dec_wr_b;
  assign wr_out      = exec & dec_wr_out;
  assign imem_addr   = pc;
  assign state_o     = state;

endmodule

// File: tb/tb_td4_sequencer.sv
// Scoreboard bench for td4_sequencer: randomized programs against a behavioural TD4 model.
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [3:0] imem_addr;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [1:0] alu_src_sel;
  logic [3:0] imm_o;
  logic       alu_carry;
  logic       wr_a, wr_b, wr_out;
  logic [3:0] pc;
  logic       carry;
  logic [1:0] state_o;

  td4_sequencer #(.PC_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef TD4_SINGLE_STEP_EN
    .step        (step),
`endif
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .alu_src_sel (alu_src_sel),
    .imm_o       (imm_o),
    .alu_carry   (alu_carry),
    .wr_a        (wr_a),
    .wr_b        (wr_b),
    .wr_out      (wr_out),
    .pc          (pc),
    .carry       (carry),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [1:0] sel;
    logic [3:0] imm;
    logic       wa, wb, wo;
    logic [3:0] npc;
    logic       ncy;
  } exp_t;

  exp_t sbq[$];
  int   m_pc;
  bit   m_cy;

  // Architectural effect of one TD4 instruction, straight from the ISA table
  function automatic exp_t model(input logic [7:0] ins, input bit acy);
    exp_t e;
    logic [3:0] op, im;
    op = ins[7:4];
    im = ins[3:0];
    e.addr = 4'(m_pc);
    e.sel = 2'd3; e.imm = 4'd0; e.wa = 1'b0; e.wb = 1'b0; e.wo = 1'b0;
    e.npc = 4'((m_pc + 1) % 16);
    e.ncy = 1'b0;
    case (op)
      4'd0:  begin e.sel = 2'd0; e.imm = im; e.wa = 1'b1; e.ncy = acy; end
      4'd5:  begin e.sel = 2'd1; e.imm = im; e.wb = 1'b1; e.ncy = acy; end
      4'd3:  begin e.imm = im; e.wa = 1'b1; end
      4'd7:  begin e.imm = im; e.wb = 1'b1; end
      4'd1:  begin e.sel = 2'd1; e.wa = 1'b1; end
      4'd4:  begin e.sel = 2'd0; e.wb = 1'b1; end
      4'd2:  begin e.sel = 2'd2; e.wa = 1'b1; end
      4'd6:  begin e.sel = 2'd2; e.wb = 1'b1; end
      4'd9:  begin e.sel = 2'd1; e.wo = 1'b1; end
      4'd11: begin e.imm = im; e.wo = 1'b1; end
      4'd15: e.npc = im;
      4'd14: if (!m_cy) e.npc = im;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: checks each EXEC cycle against the scoreboard head, then the pc/carry it leaves behind
  exp_t cur;
  bit   pend = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (state_o == 2'd2) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: EXEC with empty scoreboard at %0t", $time);
        end else begin
          cur = sbq.pop_front();
          check("exec_addr", int'(pc), int'(cur.addr));
          check("exec_sel", int'(alu_src_sel), int'(cur.sel));
          check("exec_imm", int'(imm_o), int'(cur.imm));
          check("exec_wr", int'({wr_a, wr_b, wr_out}), int'({cur.wa, cur.wb, cur.wo}));
          check("exec_req", int'(imem_req), 0);
          pend = 1'b1;
        end
      end else begin
        if (pend) begin
          check("pc_next", int'(pc), int'(cur.npc));
          check("carry_next", int'(carry), int'(cur.ncy));
          pend = 1'b0;
        end
        // strobes idle, sel=zero, imm=0 outside EXEC
        check("idle_outputs", int'({wr_a, wr_b, wr_out, alu_src_sel, imm_o}), 'h30);
      end
    end
  end

  // Caller sits at posedge+1 with the DUT in FETCH
  task automatic run_instr(input logic [7:0] ins, input int waits, input bit acy);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      imem_ack  = 1'b0;
      imem_data = 8'($urandom);
      check("wait_req", int'(imem_req), 1);
      check("wait_addr", int'(imem_addr), m_pc);
      @(posedge clk); #1;
    end
    imem_data = ins;
    imem_ack  = 1'b1;
    alu_carry = acy;
    e = model(ins, acy);
    sbq.push_back(e);
    m_pc = int'(e.npc);
    m_cy = e.ncy;
    @(posedge clk); #1;
    imem_ack  = 1'b0;
    imem_data = 8'($urandom);
    @(posedge clk); #1;
    alu_carry = 1'($urandom_range(0, 1));
`ifdef TD4_SINGLE_STEP_EN
    begin
      int k;
      k = int'($urandom_range(0, 12));
      for (int i = 0; i < k; i++) begin
        check("stall_state", int'(state_o), 3);
        check("stall_req", int'(imem_req), 0);
        @(posedge clk); #1;
      end
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      check("step_fetch", int'(state_o), 1);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    rst = 1'b1; imem_ack = 1'b1; imem_data = 8'h00; alu_carry = 1'b1; step = 1'b0;
    m_pc = 0; m_cy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state_o), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_req", int'(imem_req), 0);
    check("rst_outs", int'({wr_a, wr_b, wr_out, alu_src_sel, imm_o}), 'h30);
    rst = 1'b0; imem_ack = 1'b0;
    @(posedge clk); #1;
    check("first_fetch_state", int'(state_o), 1);
    check("first_fetch_req", int'(imem_req), 1);

    // back-to-back NOPs: wrap 15->0, two cycles each when not single-stepping
    t0 = $time;
    for (int i = 0; i < 18; i++) run_instr(8'h80, 0, 1'($urandom_range(0, 1)));
`ifndef TD4_SINGLE_STEP_EN
    check("nop_throughput_cycles", int'(($time - t0) / 10), 36);
`endif
    check("nop_wrap_pc", int'(pc), 2);

    run_instr(8'h33, 0, 1'b0);
    run_instr(8'h0E, 1, 1'b1);
    check("add_carry_set", int'(carry), 1);
    run_instr(8'hE5, 0, 1'b0);
    check("jnc_not_taken_pc", int'(pc), 5);
    check("jnc_clears_carry", int'(carry), 0);
    run_instr(8'hE5, 2, 1'b1);
    check("jnc_taken_pc", int'(pc), 5);
    run_instr(8'hF2, 0, 1'b0);
    run_instr(8'hF9, 0, 1'b0);
    check("jmp_pc", int'(imem_addr), 9);
    run_instr(8'hB7, 0, 1'b0);

    // ack withheld; reset lands in the third wait cycle
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("hold_req", int'(imem_req), 1);
      check("hold_addr", int'(imem_addr), m_pc);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midfetch_rst_state", int'(state_o), 0);
    check("midfetch_rst_pc", int'(pc), 0);
    check("midfetch_rst_carry", int'(carry), 0);
    rst = 1'b0;
    m_pc = 0; m_cy = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++)
      run_instr(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Multi-cycle control unit for the 4-bit TD4-style datapath: accumulators A/B, 4-bit adder, output latch.
- Owns the program counter and carry flag.
- Fetches 8-bit instructions over a req/ack handshake, decodes the full TD4 ISA, and drives the datapath's source-select and write-enable strobes, one instruction at a time.
- Sits between instruction memory (ROM or Tiny Tapeout input pins) and the datapath.

Parameters:
- PC_WIDTH, 4, program counter / instruction address width.
- DATA_WIDTH, 4, immediate and datapath width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- imem_addr  out  PC_WIDTH  instruction address (= pc)
- imem_req  out  1  fetch request, held until ack
- imem_ack  in  1  instruction data valid this cycle
- imem_data  in  8  instruction; [7:4] opcode, [3:0] immediate
- alu_src_sel  out  2  adder operand: 00=A, 01=B, 10=IN port, 11=zero
- imm_o  out  DATA_WIDTH  immediate to adder second operand
- alu_carry  in  1  adder carry-out for current operands (combinational from datapath)
- wr_a  out  1  write adder result to A (1-cycle pulse)
- wr_b  out  1  write adder result to B (1-cycle pulse)
- wr_out  out  1  write adder result to output latch (1-cycle pulse)
- pc  out  PC_WIDTH  current program counter
- carry  out  1  carry flag
- state_o  out  2  FSM state for debug

Behaviour:
- Reset (rst=1 at posedge):
  - state=RESET; pc=0; carry=0; imem_req=0; wr_*=0; alu_src_sel=11; imm_o=0; ir=0.
  - rst wins over every other event, including mid-fetch and during EXEC.
  - An ack arriving in the reset cycle is discarded.
- States: RESET(00), FETCH(01), EXEC(10), STALL(11, optional feature only).
- RESET -> FETCH unconditionally, next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: ir<=imem_data, go to EXEC.
  - Without ack: stay in FETCH, req and addr held stable.
  - No minimum latency; ack in the first FETCH cycle is legal.
- EXEC (exactly 1 cycle): decode ir, drive alu_src_sel/imm_o combinationally, pulse at most one wr_*, update pc and carry at the posedge, return to FETCH. imem_req=0 in EXEC.
- Minimum throughput: 2 cycles per instruction.
- Decode (sel, imm, write, carry update):
  - 0000 ADD A,Im: sel=A, imm=Im, wr_a, carry<=alu_carry
  - 0101 ADD B,Im: sel=B, imm=Im, wr_b, carry<=alu_carry
  - 0011 MOV A,Im: sel=zero, imm=Im, wr_a
  - 0111 MOV B,Im: sel=zero, imm=Im, wr_b
  - 0001 MOV A,B: sel=B, imm=0, wr_a
  - 0100 MOV B,A: sel=A, imm=0, wr_b
  - 0010 IN A: sel=IN, imm=0, wr_a
  - 0110 IN B: sel=IN, imm=0, wr_b
  - 1001 OUT B: sel=B, imm=0, wr_out
  - 1011 OUT Im: sel=zero, imm=Im, wr_out
  - 1111 JMP Im: pc<=Im
  - 1110 JNC Im: pc<=Im if carry==0, else pc+1; tests the flag value from before this instruction
  - all other opcodes: NOP
- Carry rules:
  - Only the two ADDs load alu_carry.
  - Every other instruction, including JNC, JMP and NOP, clears carry to 0.
- PC arithmetic:
  - Non-jump: pc<=pc+1, modulo 2^PC_WIDTH; 15 wraps to 0.
  - Jump target is Im zero-extended to PC_WIDTH.
- Outputs outside EXEC: wr_*=0, alu_src_sel=11, imm_o=0.

Optional Feature:
- Macro: TD4_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - After EXEC, FSM enters STALL, with all strobes 0 and imem_req=0.
  - Leaves STALL for FETCH on the first cycle with step=1; holding step high advances one instruction per STALL visit.
  - rst from STALL gives RESET.
- Undefined:
  - No step port; STALL is unreachable; EXEC -> FETCH directly.

Decomposition:
- Package td4_pkg:
  - opcode localparams: OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A, OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B, OP_OUT_B, OP_OUT_IM, OP_JNC, OP_JMP
  - state encodings
  - SEL_A/SEL_B/SEL_IN/SEL_ZERO
- One natural sub-module: td4_decoder. It is combinational: opcode + carry in; sel, imm-enable, wr_a/wr_b/wr_out, jump_taken, carry_load out.
- FSM, pc and carry registers stay in td4_sequencer.

Test Plan:
- Reset, then imem_ack tied high: imem_addr sequence 0,1,2,... one new address every 2 cycles; pc wraps 15->0; carry=0 throughout with NOP (1000) data.
- Program MOV A,3 (0x33), ADD A,14 (0x0E), alu_carry=1 in 2nd EXEC: wr_a pulses in both EXECs; sel=11 then 00; imm_o=3 then 14; carry=1 after the 2nd EXEC.
- JNC with carry=1 (0xE5 after the ADD above) -> pc=pc+1 and carry cleared; second JNC 0xE5 -> pc=5.
- JMP 0xF9 at pc=2 -> next imem_addr=9; then OUT Im 0xB7 -> wr_out pulse, sel=11, imm_o=7, no wr_a/wr_b.
- imem_ack withheld 5 cycles: imem_req and imem_addr stable, no strobes; assert rst in the 3rd wait cycle -> next cycle pc=0, carry=0, state=RESET.
- With TD4_SINGLE_STEP_EN: step=0 after the first EXEC -> state_o=11 indefinitely, imem_req=0; one-cycle step pulse -> exactly one further instruction executes.
